tt_vpu_ovi_issue_ctrl: RTL

Core-side issue controller that sits directly upstream of `tt_vpu_ovi` and drives its issue, dispatch and completion buses.
- Accepts vector instructions from the core pipeline.
- Allocates OVI scoreboard IDs (sb_id) and meters issue against VPU credits.
- Converts in-order core commit/kill decisions into `dispatch_next_senior`/`dispatch_kill`.
- Retires completions back to the core, freeing sb_ids.

---
 rtl/tt_vpu_ovi_pkg.sv | 26 ++
 rtl/tt_vpu_ovi_age_fifo.sv | 51 +++++
 rtl/tt_vpu_ovi_issue_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tt_vpu_ovi_pkg.sv
// rtl/tt_vpu_ovi_pkg.sv - shared types and widths for the OVI issue controller
package tt_vpu_ovi_pkg;

  localparam int OVI_VCSR_W   = 40;
  localparam int OVI_VSTART_W = 14;
  localparam int OVI_SB_W     = 5;

  typedef logic [OVI_SB_W-1:0] sb_id_t;

  typedef struct packed {
    logic [31:0]           inst;
    logic [63:0]           scalar_opnd;
    logic [OVI_VCSR_W-1:0] vcsr;
    logic                  lmulb2;
  } ovi_issue_t;

  typedef struct packed {
    sb_id_t                  sb_id;
    logic [4:0]              fflags;
    logic [63:0]             dest_reg;
    logic                    vxsat;
    logic [OVI_VSTART_W-1:0] vstart;
    logic                    illegal;
  } ovi_completed_t;

endpackage

// File: rtl/tt_vpu_ovi_age_fifo.sv
// rtl/tt_vpu_ovi_age_fifo.sv - 32-entry sb_id FIFO holding issued-but-undispatched ids in age order
module tt_vpu_ovi_age_fifo
  import tt_vpu_ovi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  sb_id_t     push_sb_id_i,
  input  logic       pop_i,
  output sb_id_t     head_sb_id_o,
  output logic       empty_o,
  output logic [5:0] count_o
);

  localparam logic [5:0] DEPTH = 6'd32;

  sb_id_t     mem_q [32];
  logic [5:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic       push_ok;
  logic       pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o      = wr_ptr_q - rd_ptr_q;
  assign empty_o      = (count_o == 6'd0);
  assign push_ok      = push_i & (count_o != DEPTH);
  assign pop_ok       = pop_i & ~empty_o;
  assign head_sb_id_o = mem_q[rd_ptr_q[4:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 6'd1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[4:0]] <= push_sb_id_i;
  end

endmodule

// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// rtl/tt_vpu_ovi_issue_ctrl.sv - core-side OVI issue/dispatch/completion controller
// Define TT_VPU_OVI_ISSUE_CHECK_EN to compile in the sticky protocol error detectors.
module tt_vpu_ovi_issue_ctrl #(
  parameter int INIT_CREDITS = 4,
  parameter int NUM_SB       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_inst,
  input  logic [63:0] req_scalar_opnd,
  input  logic [39:0] req_vcsr,
  input  logic        req_vcsr_lmulb2,
  output logic [4:0]  req_sb_id,
  output logic        issue_valid,
  output logic [31:0] issue_inst,
  output logic [4:0]  issue_sb_id,
  output logic [63:0] issue_scalar_opnd,
  output logic [39:0] issue_vcsr,
  output logic        issue_vcsr_lmulb2,
  input  logic        issue_credit,
  input  logic        commit_valid,
  input  logic        commit_kill,
  output logic        commit_ready,
  output logic [4:0]  dispatch_sb_id,
  output logic        dispatch_next_senior,
  output logic        dispatch_kill,
  input  logic        completed_valid,
  input  logic [4:0]  completed_sb_id,
  input  logic [4:0]  completed_fflags,
  input  logic [63:0] completed_dest_reg,
  input  logic        completed_vxsat,
  input  logic [13:0] completed_vstart,
  input  logic        completed_illegal,
  output logic        resp_valid,
  output logic [4:0]  resp_sb_id,
  output logic [4:0]  resp_fflags,
  output logic [63:0] resp_dest_reg,
  output logic        resp_vxsat,
  output logic [13:0] resp_vstart,
  output logic        resp_illegal,
  output logic        proto_err
);

  import tt_vpu_ovi_pkg::*;

  localparam logic [4:0] INIT_CNT   = 5'(INIT_CREDITS);
  localparam logic [5:0] FIFO_DEPTH = 6'd32;

  logic [4:0]        credit_cnt_q, credit_cnt_d;
  logic [NUM_SB-1:0] busy_q, busy_d;
  logic [NUM_SB-1:0] senior_q, senior_d;

  logic           issue_valid_q;
  sb_id_t         issue_sb_id_q;
  ovi_issue_t     issue_q;
  ovi_issue_t     issue_in;
  sb_id_t         dispatch_sb_id_q;
  logic           dispatch_senior_q;
  logic           dispatch_kill_q;
  logic           resp_valid_q;
  ovi_completed_t resp_q;
  ovi_completed_t comp_in;

  sb_id_t     alloc_id;
  sb_id_t     fifo_head;
  logic       fifo_empty;
  logic [5:0] fifo_cnt;
  logic       fire;
  logic       commit_fire;

  // Lowest clear bit of the registered map, so an id freed this cycle is not reused until next cycle.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_SB - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id = sb_id_t'(i);
    end
  end

  // The FIFO count can never exceed the busy population; the term only guards the push.
  assign req_ready    = (credit_cnt_q != 5'd0) & ~&busy_q & (fifo_cnt != FIFO_DEPTH);
  assign req_sb_id    = alloc_id;
  assign fire         = req_valid & req_ready;
  assign commit_ready = ~fifo_empty;
  assign commit_fire  = commit_valid & ~fifo_empty;

  assign issue_in = {req_inst, req_scalar_opnd, req_vcsr, req_vcsr_lmulb2};
  assign comp_in  = {completed_sb_id, completed_fflags, completed_dest_reg,
                     completed_vxsat, completed_vstart, completed_illegal};

  tt_vpu_ovi_age_fifo u_age_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fire),
    .push_sb_id_i (alloc_id),
    .pop_i        (commit_fire),
    .head_sb_id_o (fifo_head),
    .empty_o      (fifo_empty),
    .count_o      (fifo_cnt)
  );

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (fire && !issue_credit) begin
      credit_cnt_d = credit_cnt_q - 5'd1;
    end else if (!fire && issue_credit && (credit_cnt_q != INIT_CNT)) begin
      credit_cnt_d = credit_cnt_q + 5'd1;
    end
  end

  // Frees are applied before the allocation so a bogus completion cannot undo a fresh grant.
  always_comb begin
    busy_d   = busy_q;
    senior_d = senior_q;
    if (commit_fire) begin
      if (commit_kill) busy_d[fifo_head]   = 1'b0;
      else             senior_d[fifo_head] = 1'b1;
    end
    if (completed_valid) begin
      busy_d[completed_sb_id]   = 1'b0;
      senior_d[completed_sb_id] = 1'b0;
    end
    if (fire) busy_d[alloc_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt_q      <= INIT_CNT;
      busy_q            <= '0;
      senior_q          <= '0;
      issue_valid_q     <= 1'b0;
      issue_sb_id_q     <= '0;
      issue_q           <= '0;
      dispatch_sb_id_q  <= '0;
      dispatch_senior_q <= 1'b0;
      dispatch_kill_q   <= 1'b0;
      resp_valid_q      <= 1'b0;
      resp_q            <= '0;
    end else begin
      credit_cnt_q      <= credit_cnt_d;
      busy_q            <= busy_d;
      senior_q          <= senior_d;
      issue_valid_q     <= fire;
      dispatch_senior_q <= commit_fire & ~commit_kill;
      dispatch_kill_q   <= commit_fire & commit_kill;
      resp_valid_q      <= completed_valid;
      if (fire) begin
        issue_sb_id_q <= alloc_id;
        issue_q       <= issue_in;
      end
      if (commit_fire)     dispatch_sb_id_q <= fifo_head;
      if (completed_valid) resp_q           <= comp_in;
    end
  end

`ifdef TT_VPU_OVI_ISSUE_CHECK_EN
  logic proto_err_q;
  logic credit_ovf;
  logic commit_empty;
  logic comp_nonsenior;

  assign credit_ovf     = issue_credit & ~fire & (credit_cnt_q == INIT_CNT);
  assign commit_empty   = commit_valid & fifo_empty;
  assign comp_nonsenior = completed_valid & ~senior_q[completed_sb_id];

  always_ff @(posedge clk) begin
    if (reset) proto_err_q <= 1'b0;
    else if (credit_ovf | commit_empty | comp_nonsenior) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  assign issue_valid          = issue_valid_q;
  assign issue_sb_id          = issue_sb_id_q;
  assign issue_inst           = issue_q.inst;
  assign issue_scalar_opnd    = issue_q.scalar_opnd;
  assign issue_vcsr           = issue_q.vcsr;
  assign issue_vcsr_lmulb2    = issue_q.lmulb2;
  assign dispatch_sb_id       = dispatch_sb_id_q;
  assign dispatch_next_senior = dispatch_senior_q;
  assign dispatch_kill        = dispatch_kill_q;
  assign resp_valid           = resp_valid_q;
  assign resp_sb_id           = resp_q.sb_id;
  assign resp_fflags          = resp_q.fflags;
  assign resp_dest_reg        = resp_q.dest_reg;
  assign resp_vxsat           = resp_q.vxsat;
  assign resp_vstart          = resp_q.vstart;
  assign resp_illegal         = resp_q.illegal;

endmodule
